// File: rtl/mmio_master_bridge_if.sv
// mmio_master_bridge_if: registered MMIO valid/ready request bus between the
// bridge (initiator) and the peripheral block (responder).
//
// Signals:
//   mmio_valid  request, held until mmio_ready is sampled
//   mmio_write  1 = write, 0 = read
//   mmio_addr   byte address
//   mmio_wdata  write data
//   mmio_wstrb  byte strobes
//   mmio_rdata  responder read data, valid with mmio_ready
//   mmio_ready  responder acknowledge, single-cycle registered pulse
//
// Modports: master (bridge side), slave (responder side).
interface mmio_master_bridge_if;
    logic        mmio_valid;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;

    modport master (
        output mmio_valid,
        output mmio_write,
        output mmio_addr,
        output mmio_wdata,
        output mmio_wstrb,
        input  mmio_rdata,
        input  mmio_ready
    );

    modport slave (
        input  mmio_valid,
        input  mmio_write,
        input  mmio_addr,
        input  mmio_wdata,
        input  mmio_wstrb,
        output mmio_rdata,
        output mmio_ready
    );
endinterface

// File: rtl/mmio_master_bridge.sv
// mmio_master_bridge: initiator side of the MMIO valid/ready protocol.
// Converts a PicoRV32-style native request (valid held until ready), already
// decoded to the peripheral window, into a registered MMIO request, waits for
// the responder's single-cycle acknowledge and returns a one-cycle cpu_ready
// with read data.
//
// Build option: define MMIO_TIMEOUT_EN to abort requests that see no
// mmio_ready within TIMEOUT_CYCLES cycles and record them in bus_err/err_addr.
// Without it, requests wait forever and bus_err/err_addr are tied to 0.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   cpu_valid     CPU request, held until cpu_ready
//   cpu_addr      byte address
//   cpu_wdata     write data
//   cpu_wstrb     byte strobes; nonzero = write, zero = read
//   cpu_rdata     read data, valid while cpu_ready = 1
//   cpu_ready     one-cycle completion pulse
//   mmio          MMIO request bus (master modport)
//   bus_err       sticky timeout flag
//   err_addr      address of the first timed-out request since last clear
//   err_clear     clears bus_err and err_addr
module mmio_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                        clk,
    input  logic                        resetn,

    input  logic                        cpu_valid,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    input  logic [3:0]                  cpu_wstrb,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_ready,

    mmio_master_bridge_if.master        mmio,

    output logic                        bus_err,
    output logic [31:0]                 err_addr,
    input  logic                        err_clear
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e state_q;

`ifdef MMIO_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 32'd1));
`else
    logic unused_cfg;

    assign bus_err    = 1'b0;
    assign err_addr   = '0;
    assign unused_cfg = err_clear ^ (TIMEOUT_CYCLES == 0) ^ (^ERR_RDATA);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= StIdle;
            mmio.mmio_valid <= 1'b0;
            mmio.mmio_write <= 1'b0;
            mmio.mmio_addr  <= '0;
            mmio.mmio_wdata <= '0;
            mmio.mmio_wstrb <= '0;
            cpu_ready       <= 1'b0;
            cpu_rdata       <= '0;
`ifdef MMIO_TIMEOUT_EN
            tmo_cnt_q       <= '0;
            bus_err         <= 1'b0;
            err_addr        <= '0;
`endif
        end else begin
`ifdef MMIO_TIMEOUT_EN
            // A timeout below overrides a simultaneous clear.
            if (err_clear) begin
                bus_err  <= 1'b0;
                err_addr <= '0;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (cpu_valid) begin
                        mmio.mmio_valid <= 1'b1;
                        mmio.mmio_write <= |cpu_wstrb;
                        mmio.mmio_addr  <= cpu_addr;
                        mmio.mmio_wdata <= cpu_wdata;
                        mmio.mmio_wstrb <= cpu_wstrb;
                        state_q         <= StReq;
`ifdef MMIO_TIMEOUT_EN
                        tmo_cnt_q       <= '0;
`endif
                    end
                end
                StReq: begin
                    // Dropping valid on the acknowledging edge keeps the
                    // responder from issuing a second ack for this request.
                    if (mmio.mmio_ready) begin
                        mmio.mmio_valid <= 1'b0;
                        cpu_ready       <= 1'b1;
                        cpu_rdata       <= mmio.mmio_write ? '0 : mmio.mmio_rdata;
                        state_q         <= StDone;
                    end
`ifdef MMIO_TIMEOUT_EN
                    else if (tmo_hit) begin
                        mmio.mmio_valid <= 1'b0;
                        cpu_ready       <= 1'b1;
                        cpu_rdata       <= mmio.mmio_write ? '0 : ERR_RDATA;
                        bus_err         <= 1'b1;
                        // Keep the first error; a same-cycle clear discards
                        // the old record so this one becomes the first.
                        if (!bus_err || err_clear) begin
                            err_addr <= mmio.mmio_addr;
                        end
                        state_q         <= StDone;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
`endif
                end
                StDone: begin
                    // cpu_valid is still high from the finished request here.
                    cpu_ready <= 1'b0;
                    cpu_rdata <= '0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
